// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the I2S audio transmitter.
package audio_pkg;

    localparam int SLOT_COUNT = 32;
    localparam int SLOT_W     = 5;
    localparam int SAMPLE_W   = 16;
    localparam int FRAME_W    = 2 * SAMPLE_W;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/audio_i2s_clkgen.sv
// SCK divider and slot counter; o_slot_end flags the clk before an SCK falling edge.
module audio_i2s_clkgen
    import audio_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_active,
    output logic              o_sck,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_slot_end
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [DIV_W-1:0]  r_div;
    logic              r_sck;
    logic [SLOT_W-1:0] r_slot;
    logic              w_tc;

    assign w_tc       = i_active && (r_div == DIV_W'(SCK_DIV - 1));
    assign o_slot_end = w_tc && r_sck;
    assign o_sck      = r_sck;
    assign o_slot     = r_slot;

    // Divider, SCK toggle and slot count; everything parks at zero while inactive.
    always_ff @(posedge clk) begin
        if (!reset_n || !i_active) begin
            r_div  <= '0;
            r_sck  <= 1'b0;
            r_slot <= '0;
        end else if (w_tc) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
                r_slot <= (r_slot == SLOT_W'(SLOT_COUNT - 1)) ? '0 : r_slot + SLOT_W'(1);
            end else begin
                r_slot <= r_slot;
            end
        end else begin
            r_div  <= r_div + DIV_W'(1);
            r_sck  <= r_sck;
            r_slot <= r_slot;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo 16-bit I2S transmitter with one-sample holding buffer.
// Define AUDIO_I2S_TX_LJ_EN for left-justified framing (no delay slot).
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                i2s_sck,
    output logic                i2s_lrck,
    output logic                i2s_sdata,
    output logic                underrun
);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic              w_active;
    logic              w_slot_end;
    logic [SLOT_W-1:0] w_slot;
    logic              w_frame_start;
    logic              w_accept;
    logic [FRAME_W-1:0] w_load;

    logic               r_buf_full;
    logic [FRAME_W-1:0] r_buf;
    logic [FRAME_W-1:0] r_last;
    logic [FRAME_W-1:0] r_shift;
    logic               r_sdata;
    logic               r_underrun;

    assign w_active = (r_state == RUN) && en;

    audio_i2s_clkgen #(
        .SCK_DIV   (SCK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_active  (w_active),
        .o_sck     (i2s_sck),
        .o_slot    (w_slot),
        .o_slot_end(w_slot_end)
    );

    // A frame starts on the STOP->RUN edge and whenever slot 31 ends.
    assign w_frame_start = ((r_state == STOP) && en)
                         || (w_slot_end && (w_slot == SLOT_W'(SLOT_COUNT - 1)));
    assign w_accept      = in_valid && !r_buf_full;
    assign w_load        = r_buf_full ? r_buf : r_last;

    assign in_ready  = !r_buf_full;
    assign i2s_lrck  = w_slot[SLOT_W-1];
    assign i2s_sdata = r_sdata;
    assign underrun  = r_underrun;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STOP: begin
                if (en) w_state_nxt = RUN;
                else    w_state_nxt = STOP;
            end
            RUN: begin
                if (!en) w_state_nxt = STOP;
                else     w_state_nxt = RUN;
            end
            default: w_state_nxt = STOP;
        endcase
    end

    // Holding buffer, shifter and serial data; shifter is cleared while stopped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf_full <= 1'b0;
            r_buf      <= '0;
            r_last     <= '0;
            r_shift    <= '0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && !r_buf_full;

            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf      <= {in_left, in_right};
            end else if (w_frame_start) begin
                r_buf_full <= 1'b0;
            end else begin
                r_buf_full <= r_buf_full;
            end

            if (w_frame_start && r_buf_full) begin
                r_last <= r_buf;
            end else begin
                r_last <= r_last;
            end

            if (!en) begin
                r_sdata <= 1'b0;
                r_shift <= '0;
            end else if (w_frame_start) begin
`ifdef AUDIO_I2S_TX_LJ_EN
                r_sdata <= w_load[FRAME_W-1];
                r_shift <= {w_load[FRAME_W-2:0], 1'b0};
`else
                // Slot 0 still carries the previous right LSB, left behind in bit 31.
                r_sdata <= r_shift[FRAME_W-1];
                r_shift <= w_load;
`endif
            end else if (w_slot_end) begin
                r_sdata <= r_shift[FRAME_W-1];
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end else begin
                r_sdata <= r_sdata;
                r_shift <= r_shift;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at SCK_DIV=2 (4 clk per SCK, 128 clk per frame).
module tb_audio_i2s_tx;

    localparam int SCK_DIV   = 2;
    localparam int SLOT_CLK  = 2 * SCK_DIV;
    localparam int FRAME_CLK = 32 * SLOT_CLK;
`ifdef AUDIO_I2S_TX_LJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        i2s_sck;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .SCK_DIV  (SCK_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_left  (in_left),
        .in_right (in_right),
        .i2s_sck  (i2s_sck),
        .i2s_lrck (i2s_lrck),
        .i2s_sdata(i2s_sdata),
        .underrun (underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check_eq({tag, " sck"},      32'(i2s_sck),   32'd0);
        check_eq({tag, " lrck"},     32'(i2s_lrck),  32'd0);
        check_eq({tag, " sdata"},    32'(i2s_sdata), 32'd0);
        check_eq({tag, " underrun"}, 32'(underrun),  32'd0);
        check_eq({tag, " in_ready"}, 32'(in_ready),  32'(exp_ready));
    endtask

    // Samples ncyc clocks following a frame-start edge; w is {left,right}.
    task automatic check_frame(input int fid, input logic [31:0] w, input logic prev_lsb,
                               input logic exp_under, input int ncyc);
        int   s;
        int   ph;
        int   idx;
        logic exp_bit;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            s   = c / SLOT_CLK;
            ph  = c % SLOT_CLK;
            idx = LJ ? (31 - s) : ((s == 0) ? 0 : (32 - s));
            exp_bit = (!LJ && (s == 0)) ? prev_lsb : w[idx];
            check_eq($sformatf("f%0d c%0d sck", fid, c),      32'(i2s_sck),   32'(ph >= SCK_DIV));
            check_eq($sformatf("f%0d c%0d lrck", fid, c),     32'(i2s_lrck),  32'(s >= 16));
            check_eq($sformatf("f%0d c%0d sdata", fid, c),    32'(i2s_sdata), 32'(exp_bit));
            check_eq($sformatf("f%0d c%0d underrun", fid, c), 32'(underrun),  32'((c == 0) && exp_under));
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_left  = 16'h0000;
        in_right = 16'h0000;
        repeat (3) @(negedge clk);
        check_idle("reset", 1'b1);
        reset_n = 1'b1;

        // Load first sample while stopped, then start.
        @(negedge clk);
        in_valid = 1'b1;
        in_left  = 16'h8001;
        in_right = 16'h7FFE;
        @(negedge clk);
        check_idle("stop_loaded", 1'b0);
        in_valid = 1'b0;
        en       = 1'b1;

        // Frame 1: buffered sample, in_ready back one clk after frame start.
        fork
            check_frame(1, 32'h8001_7FFE, 1'b0, 1'b0, FRAME_CLK);
            begin
                @(negedge clk);
                check_eq("f1 ready_after_start", 32'(in_ready), 32'd1);
            end
        join

        // Frame 2: underrun repeat; offer 0x1234 then hold valid with 0x5678.
        fork
            check_frame(2, 32'h8001_7FFE, 1'b0, 1'b1, FRAME_CLK);
            begin
                repeat (12) @(negedge clk);
                in_valid = 1'b1;
                in_left  = 16'h1234;
                in_right = 16'hABCD;
                @(negedge clk);
                check_eq("f2 ready_low", 32'(in_ready), 32'd0);
                in_left  = 16'h5678;
                in_right = 16'h5678;
                repeat (115) @(negedge clk);
                check_eq("f2 ready_still_low", 32'(in_ready), 32'd0);
                in_valid = 1'b0;
            end
        join

        // Frame 3: 0x1234 sent, next sample buffered, en dropped in slot 20.
        fork
            check_frame(3, 32'h1234_ABCD, 1'b0, 1'b0, 83);
            begin
                @(negedge clk);
                check_eq("f3 ready_after_start", 32'(in_ready), 32'd1);
                repeat (44) @(negedge clk);
                in_valid = 1'b1;
                in_left  = 16'h00F1;
                in_right = 16'h0F01;
                @(negedge clk);
                check_eq("f3 ready_low", 32'(in_ready), 32'd0);
                in_valid = 1'b0;
                repeat (37) @(negedge clk);
                en = 1'b0;
            end
        join
        @(negedge clk);
        check_idle("en_low", 1'b0);
        repeat (3) @(negedge clk);
        check_idle("stopped", 1'b0);
        en = 1'b1;

        // Frame 4: restart at slot 0 with buffered sample.
        fork
            check_frame(4, 32'h00F1_0F01, 1'b0, 1'b0, FRAME_CLK);
            begin
                @(negedge clk);
                check_eq("f4 ready_after_start", 32'(in_ready), 32'd1);
            end
        join

        // Frame 5: underrun repeat (slot 0 = prior right LSB), fill buffer, reset mid-frame.
        fork
            check_frame(5, 32'h00F1_0F01, 1'b1, 1'b1, 60);
            begin
                repeat (21) @(negedge clk);
                in_valid = 1'b1;
                in_left  = 16'hAAAA;
                in_right = 16'h5555;
                @(negedge clk);
                check_eq("f5 ready_low", 32'(in_ready), 32'd0);
                in_valid = 1'b0;
                repeat (38) @(negedge clk);
                reset_n = 1'b0;
            end
        join
        @(negedge clk);
        check_idle("reset_mid_frame", 1'b1);
        reset_n = 1'b1;

        // Frame 6: buffer and last sample cleared by reset -> zeros with underrun.
        check_frame(6, 32'h0000_0000, 1'b0, 1'b1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter SCK_DIV, default 4: clk cycles per SCK half-period (legal ≥1); one bit slot = 2*SCK_DIV clk.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port en  input  1  transmitter run enable.
REQ-005 SHALL have port in_valid  input  1  stereo sample offered.
REQ-006 SHALL have port in_ready  output  1  holding buffer empty, sample accepted when in_valid&in_ready.
REQ-007 SHALL have port in_left  input  16  signed left sample (filtered audio).
REQ-008 SHALL have port in_right  input  16  signed right sample.
REQ-009 SHALL have port i2s_sck  output  1  bit clock.
REQ-010 SHALL have port i2s_lrck  output  1  word select, 0=left, 1=right.
REQ-011 SHALL have port i2s_sdata  output  1  serial data, MSB first.
REQ-012 SHALL have port underrun  output  1  one-clk pulse when a frame starts with holding buffer empty.

Function
REQ-013 SHALL use states STOP and RUN; STOP->RUN on clk where en=1; RUN->STOP on clk where en=0.
REQ-014 SHALL in STOP hold i2s_sck=0, i2s_lrck=0, i2s_sdata=0, divider and slot counter at 0; holding buffer and handshake keep operating.
REQ-015 SHALL in RUN count divider 0..SCK_DIV-1, toggling i2s_sck at terminal count; SCK low in first half of slot, high in second; slot boundary = SCK falling edge.
REQ-016 SHALL count slots 0..31 per frame, wrapping 31->0; first slot after STOP->RUN is slot 0.
REQ-017 SHALL drive i2s_lrck=0 in slots 0..15, 1 in slots 16..31.
REQ-018 SHALL at each slot-0 start (frame start) move holding buffer into 32-bit shift register {left,right} and free buffer (in_ready=1 next clk).
REQ-019 SHALL at frame start with empty buffer reload the previous frame's sample (zeros if none since reset) and pulse underrun for exactly one clk.
REQ-020 SHALL in standard mode place left MSB in slot 1, left LSB slot 16, right MSB slot 17, right LSB slot 0 of the following frame (one-slot delay after LRCK edge).
REQ-021 SHALL change i2s_sdata only at slot boundaries.
REQ-022 SHALL accept a sample when in_valid&in_ready; in_ready drops next clk; in_valid while in_ready=0 is ignored (no overwrite).
REQ-023 SHALL, when acceptance and frame-start load occur in the same clk (buffer empty), flag underrun, load old sample, and keep the new sample for the next frame.
REQ-024 SHALL give latency: sample accepted before a frame start appears as left MSB on i2s_sdata in that frame (slot 1 standard, slot 0 left-justified).
REQ-025 SHALL on en falling mid-frame abandon the frame immediately; partially sent sample is not resent.

Reset
REQ-026 SHALL on reset_n=0 at posedge clk enter STOP, clear counters, buffer empty, last sample=0; outputs: i2s_sck=0, i2s_lrck=0, i2s_sdata=0, in_ready=1, underrun=0.
REQ-027 SHALL let reset_n override en and in_valid in the same clk.

Configuration
REQ-028 SHALL with macro AUDIO_I2S_TX_LJ_EN defined emit left-justified format: left MSB slot 0, LSB slot 15, right MSB slot 16, LSB slot 31, no delay slot.
REQ-029 SHALL without AUDIO_I2S_TX_LJ_EN emit standard I2S per REQ-020.

Structure
REQ-030 SHALL place slot count (32), sample width (16), and STOP/RUN state enum in shared package audio_pkg.
REQ-031 SHALL implement SCK divider/slot counter as sub-module audio_i2s_clkgen (outputs sck, slot index, slot-boundary strobe); shifter and handshake in top.

Verification
REQ-032 SHALL test: reset, SCK_DIV=2, en=1, sample L=0x8001 R=0x7FFE -> sck period 4 clk, frame 128 clk, standard: slot1=1, slots2..15=0, slot16=1; right slots 17=0,18..31=1, next slot0=0.
REQ-033 SHALL test: same with AUDIO_I2S_TX_LJ_EN -> slot0=1, slot15=1, slot16=0, slot31=0; lrck rises at slot 16 start.
REQ-034 SHALL test: no sample after first -> underrun pulses 1 clk at each frame start, previous 0x8001/0x7FFE repeated.
REQ-035 SHALL test: in_valid held with 0x1234 then 0x5678 while in_ready=0 -> 0x5678 ignored, 0x1234 sent, in_ready returns 1 clk after frame start.
REQ-036 SHALL test: en deasserted at slot 20 -> next clk sck/lrck/sdata=0; en reasserted -> frame restarts at slot 0, buffered sample sent.
REQ-037 SHALL test: reset_n low mid-frame with buffer full -> all outputs per REQ-026 next clk, in_ready=1.
